l2_input_arbiter: RTL and testbench

L2_INPUT_ARBITER -- requirements
Module: l2_input_arbiter

---
 rtl/l2_input_arbiter.sv | 157 +++++++++++++++
 tb/tb_l2_input_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_input_arbiter.sv
// L2 input arbiter: picks one request per transaction and holds it through issue and busy.
// Define L2_ARB_STARVE_GUARD_EN to let a waiting CPU request overtake fwd/ongoing-flush grants.
module l2_input_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_in_valid,
  input  logic       fwd_in_valid,
  input  logic       cpu_req_valid,
  input  logic       flush_valid,
  input  logic       fwd_stall,
  input  logic       set_conflict,
  input  logic       evict_stall,
  input  logic       ongoing_flush,
  input  logic       ongoing_atomic,
  input  logic       reqs_empty,
  input  logic       pipe_ready,
  input  logic       pipe_done,
  output logic       do_rsp,
  output logic       do_fwd,
  output logic       do_ongoing_flush,
  output logic       do_cpu_req,
  output logic       do_flush,
  output logic       rsp_in_ready,
  output logic       fwd_in_ready,
  output logic       cpu_req_ready,
  output logic       flush_ready,
  output logic       arb_busy,
  output logic [3:0] starve_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  localparam int G_RSP = 4;
  localparam int G_FWD = 3;
  localparam int G_OFL = 2;
  localparam int G_CPU = 1;
  localparam int G_FLS = 0;

  if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("l2_input_arbiter: STARVE_LIMIT must be in 2..15");
  end

  state_t     r_state, w_state_next;
  logic [4:0] r_grant, w_grant_next;
  logic [4:0] w_cand, w_pick;
  logic [3:0] r_starve, w_starve_next;
  logic       w_starved;
  logic       w_accept;

  // An atomic in flight leaves only rsp and fwd eligible.
  always_comb begin
    w_cand        = '0;
    w_cand[G_RSP] = rsp_in_valid;
    w_cand[G_FWD] = fwd_in_valid & ~fwd_stall;
    w_cand[G_OFL] = ongoing_flush & ~ongoing_atomic;
    w_cand[G_CPU] = cpu_req_valid & ~set_conflict & ~evict_stall & ~ongoing_flush & ~ongoing_atomic;
    w_cand[G_FLS] = flush_valid & reqs_empty & ~ongoing_atomic;
  end

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
  assign w_starved = (r_starve == LP_LIMIT);
`else
  assign w_starved = 1'b0;
`endif

  always_comb begin
    w_pick = '0;
    if (w_cand[G_RSP])                  w_pick[G_RSP] = 1'b1;
    else if (w_starved && w_cand[G_CPU]) w_pick[G_CPU] = 1'b1;
    else if (w_cand[G_FWD])             w_pick[G_FWD] = 1'b1;
    else if (w_cand[G_OFL])             w_pick[G_OFL] = 1'b1;
    else if (w_cand[G_CPU])             w_pick[G_CPU] = 1'b1;
    else if (w_cand[G_FLS])             w_pick[G_FLS] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    case (r_state)
      S_IDLE: begin
        w_grant_next = '0;
        if (|w_pick) begin
          w_state_next = S_ISSUE;
          w_grant_next = w_pick;
        end
      end
      S_ISSUE: begin
        if (pipe_ready) begin
          if (pipe_done) begin
            w_state_next = S_IDLE;
            w_grant_next = '0;
          end else begin
            w_state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (pipe_done) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

`ifdef L2_ARB_STARVE_GUARD_EN
  // Counts only at grant decisions, so a long BUSY does not inflate it.
  always_comb begin
    w_starve_next = r_starve;
    if (r_state == S_IDLE) begin
      if (!cpu_req_valid || w_pick[G_CPU])
        w_starve_next = '0;
      else if ((|w_pick) && (r_starve != LP_LIMIT))
        w_starve_next = r_starve + 4'd1;
    end
  end
`else
  assign w_starve_next = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_starve <= w_starve_next;
    end
  end

  assign w_accept = (r_state == S_ISSUE) & pipe_ready;

  assign do_rsp           = r_grant[G_RSP];
  assign do_fwd           = r_grant[G_FWD];
  assign do_ongoing_flush = r_grant[G_OFL];
  assign do_cpu_req       = r_grant[G_CPU];
  assign do_flush         = r_grant[G_FLS];

  // The ongoing-flush grant has no queue behind it, hence no ready.
  assign rsp_in_ready  = w_accept & r_grant[G_RSP];
  assign fwd_in_ready  = w_accept & r_grant[G_FWD];
  assign cpu_req_ready = w_accept & r_grant[G_CPU];
  assign flush_ready   = w_accept & r_grant[G_FLS];

  assign arb_busy   = (r_state != S_IDLE);
  assign starve_cnt = r_starve;

endmodule

// File: tb/tb_l2_input_arbiter.sv
// Directed bench for l2_input_arbiter; covers the guard-enabled build when L2_ARB_STARVE_GUARD_EN is defined.
module tb_l2_input_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsp_in_valid, fwd_in_valid, cpu_req_valid, flush_valid;
  logic       fwd_stall, set_conflict, evict_stall, ongoing_flush, ongoing_atomic, reqs_empty;
  logic       pipe_ready, pipe_done;
  logic       do_rsp, do_fwd, do_ongoing_flush, do_cpu_req, do_flush;
  logic       rsp_in_ready, fwd_in_ready, cpu_req_ready, flush_ready;
  logic       arb_busy;
  logic [3:0] starve_cnt;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  l2_input_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .fwd_in_valid(fwd_in_valid),
    .cpu_req_valid(cpu_req_valid), .flush_valid(flush_valid),
    .fwd_stall(fwd_stall), .set_conflict(set_conflict), .evict_stall(evict_stall),
    .ongoing_flush(ongoing_flush), .ongoing_atomic(ongoing_atomic), .reqs_empty(reqs_empty),
    .pipe_ready(pipe_ready), .pipe_done(pipe_done),
    .do_rsp(do_rsp), .do_fwd(do_fwd), .do_ongoing_flush(do_ongoing_flush),
    .do_cpu_req(do_cpu_req), .do_flush(do_flush),
    .rsp_in_ready(rsp_in_ready), .fwd_in_ready(fwd_in_ready),
    .cpu_req_ready(cpu_req_ready), .flush_ready(flush_ready),
    .arb_busy(arb_busy), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  wire [4:0] w_do  = {do_rsp, do_fwd, do_ongoing_flush, do_cpu_req, do_flush};
  wire [3:0] w_rdy = {rsp_in_ready, fwd_in_ready, cpu_req_ready, flush_ready};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [4:0] exp_do,
                           input logic [3:0] exp_rdy, input logic exp_busy);
    check({tag, ".do"},   32'(w_do),     32'(exp_do));
    check({tag, ".rdy"},  32'(w_rdy),    32'(exp_rdy));
    check({tag, ".busy"}, 32'(arb_busy), 32'(exp_busy));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    rsp_in_valid = 0; fwd_in_valid = 0; cpu_req_valid = 0; flush_valid = 0;
    fwd_stall = 0; set_conflict = 0; evict_stall = 0; ongoing_flush = 0;
    ongoing_atomic = 0; reqs_empty = 0; pipe_ready = 0; pipe_done = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #3;
    $display("txn reset");
    check_out("reset", 5'b00000, 4'b0000, 1'b0);
    check("reset.starve", 32'(starve_cnt), 32'd0);
    tick(); tick();
    rst = 1'b1;

    // rsp beats fwd and cpu; ready in the same cycle as the grant when pipe_ready is high
    $display("txn rsp_priority");
    rsp_in_valid = 1; fwd_in_valid = 1; cpu_req_valid = 1; pipe_ready = 1;
    settle();
    check_out("a.idle", 5'b00000, 4'b0000, 1'b0);
    tick();
    check_out("a.issue", 5'b10000, 4'b1000, 1'b1);
    rsp_in_valid = 0; fwd_in_valid = 0; cpu_req_valid = 0;
    tick();
    check_out("a.busy", 5'b10000, 4'b0000, 1'b1);
    pipe_ready = 0; pipe_done = 1;
    tick();
    check_out("a.done", 5'b00000, 4'b0000, 1'b0);
    pipe_done = 0;

    // stalled fwd yields to cpu; ready+done together returns straight to IDLE
    $display("txn fwd_stall_cpu");
    fwd_in_valid = 1; fwd_stall = 1; cpu_req_valid = 1;
    tick();
    check_out("b.cpu", 5'b00010, 4'b0000, 1'b1);
    pipe_ready = 1; pipe_done = 1;
    settle();
    check_out("b.accept", 5'b00010, 4'b0010, 1'b1);
    tick();
    set_conflict = 1; pipe_ready = 0; pipe_done = 0;
    settle();
    check_out("b.ret", 5'b00000, 4'b0000, 1'b0);
    tick();
    check_out("b.conflict", 5'b00000, 4'b0000, 1'b0);
    clear_inputs();

    // grant held while pipe_ready is low, even with a higher-priority request arriving
    $display("txn cpu_hold");
    cpu_req_valid = 1;
    tick();
    rsp_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_out($sformatf("c.hold%0d", i), 5'b00010, 4'b0000, 1'b1);
      tick();
    end
    pipe_ready = 1;
    settle();
    check_out("c.accept", 5'b00010, 4'b0010, 1'b1);
    tick();
    pipe_ready = 0; cpu_req_valid = 0; rsp_in_valid = 0;
    settle();
    check_out("c.busy", 5'b00010, 4'b0000, 1'b1);
    tick(); tick();
    pipe_done = 1;
    settle();
    check_out("c.busy3", 5'b00010, 4'b0000, 1'b1);
    tick();
    check_out("c.idle", 5'b00000, 4'b0000, 1'b0);
    pipe_done = 0;

    // flush waits for reqs_empty
    $display("txn flush");
    flush_valid = 1;
    tick();
    check_out("d.blocked", 5'b00000, 4'b0000, 1'b0);
    reqs_empty = 1;
    tick();
    check_out("d.grant", 5'b00001, 4'b0000, 1'b1);
    pipe_ready = 1; pipe_done = 1;
    settle();
    check_out("d.accept", 5'b00001, 4'b0001, 1'b1);
    tick();
    clear_inputs();
    settle();
    check_out("d.idle", 5'b00000, 4'b0000, 1'b0);

    // ongoing flush grant pulses no ready
    $display("txn ongoing_flush");
    ongoing_flush = 1; cpu_req_valid = 1;
    tick();
    check_out("e.grant", 5'b00100, 4'b0000, 1'b1);
    pipe_ready = 1;
    settle();
    check_out("e.accept", 5'b00100, 4'b0000, 1'b1);
    pipe_done = 1;
    tick();
    clear_inputs();
    settle();
    check_out("e.idle", 5'b00000, 4'b0000, 1'b0);

    // atomic in flight: only rsp/fwd eligible
    $display("txn atomic");
    ongoing_atomic = 1; cpu_req_valid = 1; flush_valid = 1; reqs_empty = 1; ongoing_flush = 1;
    tick();
    check_out("f.none", 5'b00000, 4'b0000, 1'b0);
    fwd_in_valid = 1;
    tick();
    check_out("f.fwd", 5'b01000, 4'b0000, 1'b1);
    pipe_ready = 1; pipe_done = 1;
    settle();
    check_out("f.accept", 5'b01000, 4'b0100, 1'b1);
    tick();
    clear_inputs();

    // pipe_done in IDLE has no effect
    $display("txn idle_done");
    pipe_done = 1;
    tick();
    check_out("g.idle", 5'b00000, 4'b0000, 1'b0);
    pipe_done = 0;

    // starvation: fwd keeps winning while cpu waits
    $display("txn starve");
    fwd_in_valid = 1; cpu_req_valid = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s.do%0d", i), 32'(w_do), 32'(5'b01000));
      check($sformatf("s.cnt%0d", i), 32'(starve_cnt), GUARD ? 32'(i + 1) : 32'd0);
      pipe_ready = 1; pipe_done = 1;
      tick();
      pipe_ready = 0; pipe_done = 0;
    end
    tick();
    check("s.after.do", 32'(w_do), GUARD ? 32'(5'b00010) : 32'(5'b01000));
    check("s.after.cnt", 32'(starve_cnt), 32'd0);
    pipe_ready = 1; pipe_done = 1;
    tick();
    clear_inputs();

    // asynchronous reset during BUSY
    $display("txn reset_busy");
    rsp_in_valid = 1;
    tick();
    pipe_ready = 1;
    tick();
    pipe_ready = 0;
    settle();
    check_out("h.busy", 5'b10000, 4'b0000, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_out("h.rst", 5'b00000, 4'b0000, 1'b0);
    check("h.starve", 32'(starve_cnt), 32'd0);
    tick();
    check_out("h.held", 5'b00000, 4'b0000, 1'b0);
    rst = 1'b1;
    tick();
    check_out("h.first", 5'b10000, 4'b0000, 1'b1);
    pipe_ready = 1; pipe_done = 1;
    tick();
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
